turn_countdown_timer: RTL

//  Per-turn countdown timer for the game. Produces the remaining-seconds value

---
 rtl/game_pkg.sv | 14 +
 rtl/turn_countdown_timer_if.sv | 22 ++
 rtl/turn_countdown_timer_tick_gen.sv | 26 ++
 rtl/turn_countdown_timer.sv | 103 ++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: the seconds bus width/type (also feeds the 7-segment stage)
// and the turn timer state encoding.
package game_pkg;
  localparam int SEC_W = 4;

  typedef logic [SEC_W-1:0] sec_t;

  typedef enum logic {T_IDLE, T_RUN} timer_state_e;

  // Saturating decrement: the count never wraps below zero.
  function automatic sec_t sec_dec(input sec_t s);
    return (s == '0) ? '0 : sec_t'(s - sec_t'(1));
  endfunction
endpackage

// File: rtl/turn_countdown_timer_if.sv
// Control and status bundle between the game FSM (master) and the turn timer (slave).
interface turn_countdown_timer_if;
  import game_pkg::*;

  logic start;
  logic stop;
  logic pause;
  sec_t seconds;
  logic running;
  logic timeout;
  logic warn;

  modport master (
    output start, stop, pause,
    input  seconds, running, timeout, warn
  );

  modport slave (
    input  start, stop, pause,
    output seconds, running, timeout, warn
  );
endinterface

// File: rtl/turn_countdown_timer_tick_gen.sv
// tick_gen: divides clk by CLK_HZ; tick is high for one cycle per CLK_HZ enabled
// cycles. clr restarts the partial period; en low freezes it.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end
endmodule

// File: rtl/turn_countdown_timer.sv
// Per-turn countdown: reloads TURN_SECS on start, steps down once per second, pulses
// timeout at zero. Optional warn output enabled by macro TURN_TIMER_WARN_EN.
module turn_countdown_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TURN_SECS = 10,
  parameter int WARN_SECS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  turn_countdown_timer_if.slave tif
);
  if (TURN_SECS < 1 || TURN_SECS > 15) begin : g_bad_turn_secs
    $error("turn_countdown_timer: TURN_SECS must be in 1..15");
  end
  if (CLK_HZ < 2) begin : g_bad_clk_hz
    $error("turn_countdown_timer: CLK_HZ must be at least 2");
  end
  if (WARN_SECS < 0 || WARN_SECS > 15) begin : g_bad_warn_secs
    $error("turn_countdown_timer: WARN_SECS must be in 0..15");
  end

  localparam sec_t RELOAD = sec_t'(TURN_SECS);

  timer_state_e state_q, state_d;
  sec_t         sec_q, sec_d;
  logic         timeout_q, timeout_d;
  logic         tick;
  logic         presc_en;
  logic         presc_clr;

  // Prescaler only advances while counting and not paused; any start or stop
  // discards the partial second.
  assign presc_en  = (state_q == T_RUN) && !tif.pause;
  assign presc_clr = tif.start || tif.stop;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= T_IDLE;
      sec_q     <= RELOAD;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      timeout_q <= timeout_d;
    end
  end

  // Priority: start > stop > tick. A tick alongside stop is dropped.
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    timeout_d = 1'b0;
    if (tif.start) begin
      state_d = T_RUN;
      sec_d   = RELOAD;
    end else if (tif.stop && (state_q == T_RUN)) begin
      state_d = T_IDLE;
    end else if (tick) begin
      if (sec_q > sec_t'(1)) begin
        sec_d = sec_dec(sec_q);
      end else begin
        sec_d     = '0;
        state_d   = T_IDLE;
        timeout_d = 1'b1;
      end
    end
  end

  assign tif.seconds = sec_q;
  assign tif.running = (state_q == T_RUN);
  assign tif.timeout = timeout_q;

`ifdef TURN_TIMER_WARN_EN
  localparam sec_t WARN_V = sec_t'(WARN_SECS);

  logic warn_q;
  logic warn_d;

  assign warn_d = (state_d == T_RUN) && (sec_d <= WARN_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign tif.warn = warn_q;
`else
  assign tif.warn = 1'b0;
`endif
endmodule
